// File: rtl/clkdiv_ctrl.sv
// rtl/clkdiv_ctrl.sv - run-time programmable clock divider with boundary-aligned ratio updates
module clkdiv_ctrl #(
    parameter int WIDTH     = 8,
    parameter int N_DEFAULT = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_n,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [WIDTH-1:0] cur_n,
    output logic             busy,
    output logic             div_clk,
    output logic             div_tick
);

    localparam logic [WIDTH-1:0] N_RST = WIDTH'(N_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_n_q, cur_n_d;
    logic [WIDTH-1:0] pend_n_q, pend_n_d;
    logic             cfg_err_q, cfg_err_d;
    logic             div_clk_q, div_clk_d;
    logic             div_tick_q, div_tick_d;

    logic             xfer;
    logic             xfer_ok;
    logic             last;
    logic [WIDTH-1:0] cnt_inc;
    logic             active_d;

    assign cfg_ready = (state_q != PEND);
    assign busy      = (state_q == PEND);
    assign cfg_err   = cfg_err_q;
    assign cur_n     = cur_n_q;
    assign div_clk   = div_clk_q;
    assign div_tick  = div_tick_q;

    assign xfer    = cfg_valid & cfg_ready;
    assign xfer_ok = xfer & (cfg_n != '0);
    assign last    = (cnt_q == cur_n_q - WIDTH'(1));
    assign cnt_inc = last ? '0 : cnt_q + WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_n_d   = cur_n_q;
        pend_n_d  = pend_n_q;
        cfg_err_d = xfer & (cfg_n == '0);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (xfer_ok) cur_n_d = cfg_n;
                if (run)     state_d = RUN;
            end
            RUN: begin
                if (!run) begin
                    // Stopping anyway, so an accepted ratio takes effect directly.
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (xfer_ok) cur_n_d = cfg_n;
                end else begin
                    cnt_d = cnt_inc;
                    if (xfer_ok) begin
                        pend_n_d = cfg_n;
                        state_d  = PEND;
                    end
                end
            end
            PEND: begin
                if (!run) begin
                    cur_n_d = pend_n_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (last) begin
                    cur_n_d = pend_n_q;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are computed from next-state values so the flops line up with cnt/state.
        active_d   = (state_d != IDLE);
        div_tick_d = active_d & (cnt_d == '0);
        div_clk_d  = active_d & (cnt_d >= (cur_n_d >> 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_n_q    <= N_RST;
            pend_n_q   <= N_RST;
            cfg_err_q  <= 1'b0;
            div_clk_q  <= 1'b0;
            div_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_n_q    <= cur_n_d;
            pend_n_q   <= pend_n_d;
            cfg_err_q  <= cfg_err_d;
            div_clk_q  <= div_clk_d;
            div_tick_q <= div_tick_d;
        end
    end

endmodule
